// File: rtl/telemetry_packetizer_if.sv
// Byte-wide UART handshake between the telemetry packetizer (master) and a transmitter (slave).
interface telemetry_packetizer_if;
   logic [7:0] tx_byte;
   logic       transmit;
   logic       is_transmitting;

   modport master (output tx_byte, output transmit, input is_transmitting);
   modport slave  (input tx_byte, input transmit, output is_transmitting);
endinterface

// File: rtl/telemetry_packetizer.sv
// Snapshots NUM_CH sensor channels on a manual or periodic trigger and streams them to a UART as
// SYNC, SEQ, LEN, payload (channel 0 first, MSB byte first), XOR checksum.
module telemetry_packetizer #(
   parameter int unsigned NUM_CH        = 7,
   parameter int unsigned DATA_W        = 10,
   parameter logic [7:0]  SYNC_BYTE     = 8'hA5,
   parameter bit          AUTO_MODE     = 1'b1,
   parameter int unsigned PERIOD_CYCLES = 5_000_000
) (
   input  logic                     CLOCK_50,
   input  logic                     reset,
   input  logic [NUM_CH*DATA_W-1:0] ch_data,
   input  logic                     sample,
   telemetry_packetizer_if.master   uart,
   output logic                     busy,
   output logic [7:0]               frame_count,
   output logic                     overrun
);
   localparam int unsigned Bpc      = (DATA_W + 7) / 8;
   localparam int unsigned LenBytes = NUM_CH * Bpc;
   localparam int unsigned PayW     = LenBytes * 8;
   localparam int unsigned CntW     = $clog2(PERIOD_CYCLES);
   localparam int unsigned IdxW     = 9;
   localparam logic [IdxW-1:0] ChkIdx  = IdxW'(LenBytes + 3);
   localparam logic [IdxW-1:0] DoneIdx = IdxW'(LenBytes + 4);

   if (LenBytes > 255) begin : g_len_check
      $error("NUM_CH*ceil(DATA_W/8) must not exceed 255");
   end
   if (PERIOD_CYCLES < 64) begin : g_period_check
      $error("PERIOD_CYCLES must be at least 64");
   end

   typedef enum logic [2:0] {StIdle, StLoad, StIssue, StWaitStart, StWaitDone} state_e;

   state_e              state_q, state_d;
   logic [CntW-1:0]     period_q;
   logic [IdxW-1:0]     idx_q, idx_d;
   logic [7:0]          chk_q, chk_d;
   logic [PayW-1:0]     pay_q, pay_d;
   logic [1:0]          wait_q, wait_d;
   logic [7:0]          tx_byte_q, tx_byte_d;
   logic                transmit_q, transmit_d;
   logic [7:0]          fc_q, fc_d;
   logic                overrun_q, overrun_d;
   logic                tick, trigger, byte_done;
   logic [PayW-1:0]     padded;
   logic [7:0]          cur_byte;

   assign tick    = (period_q == CntW'(PERIOD_CYCLES - 1));
   assign trigger = sample || (AUTO_MODE && tick);

   // Each channel gets a Bpc-byte slot; channel 0 sits at the top so payload leaves MSB-first.
   always_comb begin
      padded = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         padded[(NUM_CH - 1 - k) * Bpc * 8 +: DATA_W] = ch_data[k * DATA_W +: DATA_W];
      end
   end

   always_comb begin
      if (idx_q == IdxW'(0))      cur_byte = SYNC_BYTE;
      else if (idx_q == IdxW'(1)) cur_byte = fc_q;
      else if (idx_q == IdxW'(2)) cur_byte = 8'(LenBytes);
      else if (idx_q == ChkIdx)   cur_byte = chk_q;
      else                        cur_byte = pay_q[PayW-1 -: 8];
   end

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      chk_d      = chk_q;
      pay_d      = pay_q;
      wait_d     = wait_q;
      tx_byte_d  = tx_byte_q;
      transmit_d = 1'b0;
      fc_d       = fc_q;
      overrun_d  = overrun_q;
      byte_done  = 1'b0;
      if (trigger && state_q != StIdle) overrun_d = 1'b1;
      unique case (state_q)
         StIdle: begin
            if (trigger) begin
               pay_d   = padded;
               state_d = StLoad;
            end
         end
         StLoad: begin
            idx_d   = '0;
            chk_d   = '0;
            state_d = StIssue;
         end
         StIssue: begin
            if (!uart.is_transmitting) begin
               tx_byte_d  = cur_byte;
               transmit_d = 1'b1;
               idx_d      = idx_q + 1'b1;
               wait_d     = '0;
               if (idx_q != '0 && idx_q != ChkIdx) chk_d = chk_q ^ cur_byte;
               if (idx_q > IdxW'(2) && idx_q != ChkIdx) pay_d = pay_q << 8;
               state_d    = StWaitStart;
            end
         end
         StWaitStart: begin
            // A UART that never raises its busy flag is treated as having sent the byte.
            if (uart.is_transmitting) state_d = StWaitDone;
            else if (wait_q == 2'd3)  byte_done = 1'b1;
            else                      wait_d = wait_q + 1'b1;
         end
         StWaitDone: begin
            if (!uart.is_transmitting) byte_done = 1'b1;
         end
         default: state_d = StIdle;
      endcase
      if (byte_done) begin
         if (idx_q == DoneIdx) begin
            state_d = StIdle;
            fc_d    = fc_q + 1'b1;
         end else begin
            state_d = StIssue;
         end
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state_q    <= StIdle;
         period_q   <= '0;
         idx_q      <= '0;
         chk_q      <= '0;
         pay_q      <= '0;
         wait_q     <= '0;
         tx_byte_q  <= '0;
         transmit_q <= 1'b0;
         fc_q       <= '0;
         overrun_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         period_q   <= tick ? '0 : period_q + 1'b1;
         idx_q      <= idx_d;
         chk_q      <= chk_d;
         pay_q      <= pay_d;
         wait_q     <= wait_d;
         tx_byte_q  <= tx_byte_d;
         transmit_q <= transmit_d;
         fc_q       <= fc_d;
         overrun_q  <= overrun_d;
      end
   end

   assign uart.tx_byte  = tx_byte_q;
   assign uart.transmit = transmit_q;
   assign busy          = (state_q != StIdle);
   assign frame_count   = fc_q;
   assign overrun       = overrun_q;
endmodule

// File: tb/tb_telemetry_packetizer.sv
// Self-checking bench: hand tables, corner-case sequences and randomized frames against a byte-level
// frame model; a second instance exercises periodic triggering.
module tb_telemetry_packetizer;
   localparam int unsigned NCH = 2;
   localparam int unsigned DW  = 10;
   localparam int unsigned W   = NCH * DW;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset, sample, busy, overrun;
   logic [W-1:0]  ch_data;
   logic [7:0]    frame_count;
   logic          rst_b, sample_b, busy_b, overrun_b;
   logic [W-1:0]  ch_data_b;
   logic [7:0]    frame_count_b;

   telemetry_packetizer_if uart_a ();
   telemetry_packetizer_if uart_b ();

   telemetry_packetizer #(.NUM_CH(NCH), .DATA_W(DW), .SYNC_BYTE(8'hA5), .AUTO_MODE(1'b0),
                          .PERIOD_CYCLES(64)) dut_a (
      .CLOCK_50(clk), .reset(reset), .ch_data(ch_data), .sample(sample), .uart(uart_a),
      .busy(busy), .frame_count(frame_count), .overrun(overrun));

   telemetry_packetizer #(.NUM_CH(NCH), .DATA_W(DW), .SYNC_BYTE(8'hA5), .AUTO_MODE(1'b1),
                          .PERIOD_CYCLES(100)) dut_b (
      .CLOCK_50(clk), .reset(rst_b), .ch_data(ch_data_b), .sample(sample_b), .uart(uart_b),
      .busy(busy_b), .frame_count(frame_count_b), .overrun(overrun_b));

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // UART model: captures pulses 1 time unit after each edge and answers with 3 busy cycles.
   logic [7:0] cap_bytes[$];
   int         cap_t[$];
   logic [7:0] exp_q[$];
   int         ubusy = 0;
   bit         uart_hold = 1'b0;
   bit         uart_never = 1'b0;
   initial begin
      uart_a.is_transmitting = 1'b0;
      forever begin
         @(posedge clk); #1;
         if (uart_a.transmit) begin
            cap_bytes.push_back(uart_a.tx_byte);
            cap_t.push_back(cyc);
            if (!uart_never) ubusy = 3;
         end else if (ubusy > 0) begin
            ubusy--;
         end
         uart_a.is_transmitting = uart_hold || (ubusy > 0);
      end
   end
   initial uart_b.is_transmitting = 1'b0;

   task automatic tick();
      @(posedge clk); #2;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic build_expected(input logic [W-1:0] d, input logic [7:0] fc);
      int bpc;
      int v;
      logic [7:0] chk;
      bpc = (DW + 7) / 8;
      exp_q.delete();
      exp_q.push_back(8'hA5);
      exp_q.push_back(fc);
      exp_q.push_back(8'(NCH * bpc));
      for (int k = 0; k < NCH; k++) begin
         v = int'(d[k*DW +: DW]);
         for (int b = bpc - 1; b >= 0; b--) exp_q.push_back(8'((v >> (8 * b)) & 255));
      end
      chk = 8'h00;
      for (int i = 1; i < exp_q.size(); i++) chk ^= exp_q[i];
      exp_q.push_back(chk);
   endtask

   task automatic compare_frame(input string name);
      check({name, "_len"}, cap_bytes.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < cap_bytes.size(); i++)
         check($sformatf("%s_byte%0d", name, i), cap_bytes[i], exp_q[i]);
   endtask

   task automatic wait_idle(input string name);
      for (int i = 0; i < 3000 && busy; i++) tick();
      check({name, "_done"}, busy, 1'b0);
   endtask

   // Fires a one-cycle sample pulse; trig_cyc is the edge that accepts it. Inputs then scramble.
   task automatic start_frame(input logic [W-1:0] d, output int trig_cyc);
      cap_bytes.delete();
      cap_t.delete();
      ch_data = d;
      sample  = 1'b1;
      tick();
      sample  = 1'b0;
      trig_cyc = cyc;
      ch_data = W'($urandom);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   typedef struct {
      logic [DW-1:0] c0;
      logic [DW-1:0] c1;
      logic [63:0]   bytes;
      logic [7:0]    fc_after;
   } vec_t;
   vec_t vecs[3];

   logic [7:0]   fc_model;
   logic [W-1:0] d;
   int           t0, drop_cyc, rel, n0;
   bit           prev;
   int           rises[$];

   initial begin
      reset = 1'b1; sample = 1'b0; ch_data = '0;
      rst_b = 1'b1; sample_b = 1'b0; ch_data_b = '0;
      vecs[0] = '{10'h3FF, 10'h001, 64'hA5_00_04_03_FF_00_01_F9, 8'd1};
      vecs[1] = '{10'h000, 10'h2AA, 64'hA5_01_04_00_00_02_AA_AD, 8'd2};
      vecs[2] = '{10'h155, 10'h3FF, 64'hA5_02_04_01_55_03_FF_AE, 8'd3};
      tick(); tick();
      reset = 1'b0;

      check("rst_tx_byte", uart_a.tx_byte, 8'h00);
      check("rst_transmit", uart_a.transmit, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_frame_count", frame_count, 8'h00);
      check("rst_overrun", overrun, 1'b0);

      for (int i = 0; i < 3; i++) begin
         logic [63:0] row;
         row = vecs[i].bytes;
         start_frame({vecs[i].c1, vecs[i].c0}, t0);
         wait_idle("tab");
         check("tab_len", cap_bytes.size(), 8);
         for (int j = 0; j < 8 && j < cap_bytes.size(); j++)
            check($sformatf("tab%0d_byte%0d", i, j), cap_bytes[j], row[63 - 8*j -: 8]);
         if (cap_t.size() > 0) check("tab_latency", cap_t[0] - t0, 2);
         check("tab_frame_count", frame_count, vecs[i].fc_after);
      end
      fc_model = 8'd3;

      // Second trigger during byte 3 is dropped and flagged.
      d = W'($urandom);
      build_expected(d, fc_model);
      start_frame(d, t0);
      for (int i = 0; i < 500 && cap_bytes.size() < 3; i++) tick();
      check("ovr_reached_byte3", busy, 1'b1);
      sample = 1'b1; tick(); sample = 1'b0;
      wait_idle("ovr");
      repeat (100) tick();
      compare_frame("ovr");
      fc_model++;
      check("ovr_flag", overrun, 1'b1);
      check("ovr_frame_count", frame_count, fc_model);

      do_reset();
      fc_model = 8'd0;
      check("rst2_overrun", overrun, 1'b0);
      check("rst2_frame_count", frame_count, 8'h00);

      // Back-pressure: line busy for 50 cycles before the trigger and beyond.
      uart_hold = 1'b1;
      repeat (50) tick();
      d = W'($urandom);
      build_expected(d, fc_model);
      start_frame(d, t0);
      repeat (20) tick();
      check("bp_no_pulse", cap_bytes.size(), 0);
      uart_hold = 1'b0;
      tick();
      drop_cyc = cyc;
      wait_idle("bp");
      if (cap_t.size() > 0) check("bp_pulse_delay", cap_t[0] - drop_cyc, 1);
      compare_frame("bp");
      fc_model++;

      // Reset during byte 4 aborts the frame.
      start_frame(W'($urandom), t0);
      for (int i = 0; i < 500 && cap_bytes.size() < 4; i++) tick();
      reset = 1'b1;
      tick();
      check("mid_rst_tx_byte", uart_a.tx_byte, 8'h00);
      check("mid_rst_transmit", uart_a.transmit, 1'b0);
      check("mid_rst_busy", busy, 1'b0);
      check("mid_rst_frame_count", frame_count, 8'h00);
      reset = 1'b0;
      n0 = cap_bytes.size();
      repeat (100) tick();
      check("mid_rst_pulses", cap_bytes.size(), 4);
      check("mid_rst_no_more", cap_bytes.size(), n0);
      fc_model = 8'd0;

      // UART that never raises its busy flag: every byte times out.
      uart_never = 1'b1;
      d = W'($urandom);
      build_expected(d, fc_model);
      start_frame(d, t0);
      wait_idle("to");
      compare_frame("to");
      fc_model++;
      for (int i = 0; i + 1 < cap_t.size(); i++)
         check($sformatf("to_spacing%0d", i), cap_t[i+1] - cap_t[i], 5);

      // Random frames through a full sequence-number wrap.
      do_reset();
      fc_model = 8'd0;
      for (int f = 0; f < 257; f++) begin
         uart_never = bit'($urandom_range(0, 1));
         d = W'($urandom);
         build_expected(d, fc_model);
         start_frame(d, t0);
         wait_idle("rnd");
         compare_frame($sformatf("rnd%0d", f));
         fc_model++;
         if (f == 255) check("wrap_frame_count", frame_count, 8'h00);
      end
      if (cap_bytes.size() > 1) check("wrap_seq_byte", cap_bytes[1], 8'h00);
      check("rnd_frame_count", frame_count, fc_model);

      // Auto mode: ticks in cycles 99/199/299 after release, each accepted at the edge closing it.
      rst_b = 1'b0;
      rel = cyc;
      prev = busy_b;
      for (int i = 0; i < 360; i++) begin
         tick();
         if (busy_b && !prev) rises.push_back(cyc - rel);
         prev = busy_b;
      end
      check("auto_count", rises.size(), 3);
      for (int i = 0; i < 3 && i < rises.size(); i++)
         check($sformatf("auto_trig%0d", i), rises[i], 100 * (i + 1));
      check("auto_frame_count", frame_count_b, 8'd3);
      check("auto_overrun", overrun_b, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
